// File: rtl/apb3_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb3_master_bridge_if
//   Bundles the command stream, response stream and APB3 requester signals
//   of apb3_master_bridge.
//   master : view taken by the bridge (drives cmd_ready, rsp_*, busy, P*)
//   slave  : view taken by the surroundings (command source, response sink
//            and APB3 completer)
//   Command : cmd_valid, cmd_ready, cmd_write, cmd_addr[31:0], cmd_wdata[31:0]
//   Response: rsp_valid, rsp_ready, rsp_rdata[31:0], rsp_err
//   Status  : busy
//   APB3    : PSEL, PENABLE, PWRITE, PADDR[31:0], PWDATA[31:0],
//             PRDATA[31:0], PREADY, PSLVERR
// ---------------------------------------------------------------------------
interface apb3_master_bridge_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        busy;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb3_master_bridge.sv
// ---------------------------------------------------------------------------
// apb3_master_bridge
//   Turns a valid/ready command stream into single APB3 SETUP/ACCESS
//   transfers and returns each completion on a valid/ready response stream.
//   One transfer is in flight at a time. A programmable timeout ends an
//   ACCESS phase whose completer never raises PREADY.
//
//   Parameters
//     TIMEOUT  : maximum ACCESS cycles per transfer, 0 disables the timeout
//     ERR_DATA : rsp_rdata returned for a timed-out transfer
//   Ports
//     PCLK     : clock, all state changes on the rising edge
//     PRESETn  : asynchronous active-low reset
//     bus      : command / response / APB3 signals (master view)
// ---------------------------------------------------------------------------
module apb3_master_bridge #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb3_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_wait;
    logic [15:0] w_wait_inc;
    logic        w_timeout;
    logic        w_cmd_fire;
    logic        w_rsp_fire;

    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    assign w_cmd_fire = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_rsp_fire = r_rsp_valid && bus.rsp_ready;

    // Count of ACCESS cycles including the current one; holds at all-ones so
    // a disabled timeout never wraps back through small values.
    assign w_wait_inc = (r_wait == 16'hFFFF) ? r_wait : (r_wait + 16'd1);

    // The current ACCESS cycle is the TIMEOUT-th one.
    assign w_timeout  = (TIMEOUT_W != 32'd0) && ({16'd0, w_wait_inc} >= TIMEOUT_W);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.cmd_valid)                w_state_next = S_SETUP;
            S_SETUP:                                    w_state_next = S_ACCESS;
            // PREADY and timeout on the same edge both lead to RESP; the
            // response datapath below gives PREADY priority.
            S_ACCESS: if (bus.PREADY || w_timeout)      w_state_next = S_RESP;
            S_RESP:   if (w_rsp_fire)                   w_state_next = S_IDLE;
            default:                                    w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered APB outputs, wait counter and response register
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= 32'd0;
            r_pwdata    <= 32'd0;
            r_wait      <= 16'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Decoded from the next state so PSEL/PENABLE line up with
            // SETUP/ACCESS while still coming straight from flops.
            r_psel    <= (w_state_next == S_SETUP) || (w_state_next == S_ACCESS);
            r_penable <= (w_state_next == S_ACCESS);

            // The command is latched once; PADDR/PWRITE/PWDATA then hold
            // through SETUP, ACCESS, RESP and the following IDLE.
            if (w_cmd_fire) begin
                r_paddr  <= bus.cmd_addr;
                r_pwrite <= bus.cmd_write;
                r_pwdata <= bus.cmd_wdata;
                r_wait   <= 16'd0;
            end

            if (r_state == S_ACCESS) begin
                r_wait <= w_wait_inc;
                if (bus.PREADY) begin
                    r_rsp_rdata <= r_pwrite ? 32'd0 : bus.PRDATA;
                    r_rsp_err   <= bus.PSLVERR;
                end else if (w_timeout) begin
                    r_rsp_rdata <= ERR_DATA;
                    r_rsp_err   <= 1'b1;
                end
            end

            // The response register is loaded on the edge that enters RESP;
            // rsp_valid follows one edge later and clears on the handshake.
            if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
            end else if (r_state == S_RESP) begin
                r_rsp_valid <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb3_master_bridge
//   Self-checking bench for apb3_master_bridge (TIMEOUT = 4). Each scenario
//   task drives one or more transfers through run_xfer, which plays the
//   command source, APB3 completer and response sink and records what it
//   observed; the scenario task then compares those observations with
//   expected values from constants or from ref_model.
// ---------------------------------------------------------------------------
module tb_apb3_master_bridge;

    localparam int          T_OUT = 4;
    localparam logic [31:0] ERR_D = 32'hDEADBEEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    apb3_master_bridge_if bus();

    apb3_master_bridge #(
        .TIMEOUT  (T_OUT),
        .ERR_DATA (ERR_D)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Observations from the most recent run_xfer
    int          o_lat;        // edges from command acceptance to rsp_valid rising
    int          o_acc;        // ACCESS cycles seen
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_setup_ok;   // first cycle after acceptance is SETUP
    logic        o_hold_ok;    // PADDR/PWRITE/PWDATA correct in every ACCESS cycle
    logic        o_stable_ok;  // response held, cmd_ready=0, PSEL=0 while waiting
    logic        o_release_ok; // IDLE with rsp_valid low right after the handshake

    // Optional command presented together with rsp_ready
    logic        q_en = 1'b0;
    logic        q_wr;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;

    // Transfer-level reference: a completer that withholds PREADY for
    // wait_cyc ACCESS cycles either completes in cycle wait_cyc+1 or is cut
    // off after T_OUT cycles, whichever comes first.
    function automatic void ref_model(input logic wr, input logic [31:0] prdata,
                                      input logic slverr, input int wait_cyc,
                                      output int acc, output logic [31:0] rd,
                                      output logic err);
        if (T_OUT != 0 && wait_cyc >= T_OUT) begin
            acc = T_OUT;
            rd  = ERR_D;
            err = 1'b1;
        end else begin
            acc = wait_cyc + 1;
            rd  = wr ? 32'd0 : prdata;
            err = slverr;
        end
    endfunction

    // Drives one transfer starting at a negedge with the bridge in IDLE.
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] prdata, input logic slverr,
                            input int wait_cyc, input int rdy_delay);
        int held = 0;
        bit hs   = 0;
        bit done = 0;
        o_lat = -1; o_acc = 0; o_rdata = 32'd0; o_err = 1'b0;
        o_setup_ok = 1'b0; o_hold_ok = 1'b1; o_stable_ok = 1'b1; o_release_ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                o_setup_ok = (bus.PSEL === 1'b1) && (bus.PENABLE === 1'b0) &&
                             (bus.cmd_ready === 1'b0) && (bus.busy === 1'b1);
                // Scramble the command inputs: the bridge must hold its copy.
                bus.cmd_valid = 1'b0;
                bus.cmd_write = ~wr;
                bus.cmd_addr  = $urandom;
                bus.cmd_wdata = $urandom;
            end
            if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
                o_acc++;
                if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== wdata)
                    o_hold_ok = 1'b0;
                bus.PREADY  = (o_acc > wait_cyc);
                bus.PRDATA  = bus.PREADY ? prdata : $urandom;
                bus.PSLVERR = bus.PREADY ? slverr : 1'($urandom);
            end else begin
                // Outside ACCESS the completer inputs must be ignored.
                bus.PREADY  = 1'($urandom);
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'($urandom);
            end
            if (hs) begin
                o_release_ok = (bus.rsp_valid === 1'b0) && (bus.cmd_ready === 1'b1) &&
                               (bus.busy === 1'b0) && (bus.PSEL === 1'b0);
                bus.rsp_ready = 1'b0;
                done = 1;
            end else if (bus.rsp_valid === 1'b1) begin
                if (o_lat < 0) begin
                    o_lat   = c - 1;
                    o_rdata = bus.rsp_rdata;
                    o_err   = bus.rsp_err;
                end else if (bus.rsp_rdata !== o_rdata || bus.rsp_err !== o_err) begin
                    o_stable_ok = 1'b0;
                end
                if (bus.PSEL !== 1'b0 || bus.cmd_ready !== 1'b0) o_stable_ok = 1'b0;
                if (held >= rdy_delay) begin
                    bus.rsp_ready = 1'b1;
                    hs = 1;
                    if (q_en) begin
                        bus.cmd_valid = 1'b1;
                        bus.cmd_write = q_wr;
                        bus.cmd_addr  = q_addr;
                        bus.cmd_wdata = q_wdata;
                    end
                end else begin
                    held++;
                end
            end else if (o_lat >= 0) begin
                o_stable_ok = 1'b0;   // rsp_valid dropped without a handshake
                done = 1;
            end
        end
        $display("xfer wr=%0d addr=%h wdata=%h wait=%0d rdy_dly=%0d -> acc=%0d lat=%0d rdata=%h err=%0d",
                 wr, addr, wdata, wait_cyc, rdy_delay, o_acc, o_lat, o_rdata, o_err);
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'd0; bus.cmd_wdata = 32'd0;
        bus.rsp_ready = 1'b0; bus.PRDATA = 32'd0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        rst_n = 1'b0;
        #12;
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
        n_vec++; if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.PSEL !== 1'b0)      begin n_bad++; $display("FAIL rst_psel: got %b want 0", bus.PSEL); end
        n_vec++; if (bus.PENABLE !== 1'b0)   begin n_bad++; $display("FAIL rst_penable: got %b want 0", bus.PENABLE); end
        n_vec++; if (bus.PADDR !== 32'd0)    begin n_bad++; $display("FAIL rst_paddr: got %h want 0", bus.PADDR); end
        n_vec++; if (bus.PWRITE !== 1'b0)    begin n_bad++; $display("FAIL rst_pwrite: got %b want 0", bus.PWRITE); end
        n_vec++; if (bus.PWDATA !== 32'd0)   begin n_bad++; $display("FAIL rst_pwdata: got %h want 0", bus.PWDATA); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        n_vec++; if (bus.rsp_err !== 1'b0)   begin n_bad++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_zero_wait();
        run_xfer(1'b1, 32'd0, 32'h12345678, 32'hCAFEF00D, 1'b0, 0, 0);
        n_vec++; if (o_setup_ok !== 1'b1) begin n_bad++; $display("FAIL wr_setup: got %b want 1", o_setup_ok); end
        n_vec++; if (o_hold_ok !== 1'b1)  begin n_bad++; $display("FAIL wr_apb_fields: got %b want 1", o_hold_ok); end
        n_vec++; if (o_acc != 1)          begin n_bad++; $display("FAIL wr_access_cycles: got %0d want 1", o_acc); end
        n_vec++; if (o_lat != 3)          begin n_bad++; $display("FAIL wr_latency: got %0d want 3", o_lat); end
        n_vec++; if (o_rdata !== 32'd0)   begin n_bad++; $display("FAIL wr_rdata: got %h want 0", o_rdata); end
        n_vec++; if (o_err !== 1'b0)      begin n_bad++; $display("FAIL wr_err: got %b want 0", o_err); end
        n_vec++; if (o_release_ok !== 1'b1) begin n_bad++; $display("FAIL wr_release: got %b want 1", o_release_ok); end
    endtask

    task automatic test_read_one_wait();
        run_xfer(1'b0, 32'h0000_0040, $urandom, 32'hA5A5A5A5, 1'b0, 1, 0);
        n_vec++; if (o_acc != 2)            begin n_bad++; $display("FAIL rd_wait_access_cycles: got %0d want 2", o_acc); end
        n_vec++; if (o_lat != 4)            begin n_bad++; $display("FAIL rd_wait_latency: got %0d want 4", o_lat); end
        n_vec++; if (o_rdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL rd_wait_rdata: got %h want a5a5a5a5", o_rdata); end
        n_vec++; if (o_err !== 1'b0)        begin n_bad++; $display("FAIL rd_wait_err: got %b want 0", o_err); end
        n_vec++; if (o_hold_ok !== 1'b1)    begin n_bad++; $display("FAIL rd_wait_apb_fields: got %b want 1", o_hold_ok); end
    endtask

    task automatic test_slave_err();
        run_xfer(1'b0, 32'd7, $urandom, 32'hDEADBEEF, 1'b1, 0, 0);
        n_vec++; if (o_err !== 1'b1)        begin n_bad++; $display("FAIL slverr_err: got %b want 1", o_err); end
        n_vec++; if (o_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL slverr_rdata: got %h want deadbeef", o_rdata); end
        n_vec++; if (o_acc != 1)            begin n_bad++; $display("FAIL slverr_access_cycles: got %0d want 1", o_acc); end
    endtask

    task automatic test_timeout();
        // PREADY never rises
        run_xfer(1'b0, $urandom, $urandom, 32'h1111_2222, 1'b0, 1000, 0);
        n_vec++; if (o_acc != 4)     begin n_bad++; $display("FAIL tmo_access_cycles: got %0d want 4", o_acc); end
        n_vec++; if (o_lat != 6)     begin n_bad++; $display("FAIL tmo_latency: got %0d want 6", o_lat); end
        n_vec++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b want 1", o_err); end
        n_vec++; if (o_rdata !== ERR_D) begin n_bad++; $display("FAIL tmo_rdata: got %h want %h", o_rdata, ERR_D); end
        // PREADY first high in the 4th ACCESS cycle: normal completion
        run_xfer(1'b0, $urandom, $urandom, 32'h0BAD_F00D, 1'b0, 3, 0);
        n_vec++; if (o_acc != 4)     begin n_bad++; $display("FAIL tmo_edge_access_cycles: got %0d want 4", o_acc); end
        n_vec++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL tmo_edge_err: got %b want 0", o_err); end
        n_vec++; if (o_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL tmo_edge_rdata: got %h want 0badf00d", o_rdata); end
        run_xfer(1'b1, $urandom, $urandom, $urandom, 1'b1, 3, 0);
        n_vec++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin n_bad++; $display("FAIL tmo_edge_wr_slverr: got err=%b rdata=%h want err=1 rdata=0", o_err, o_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1 = $urandom;
        q_en = 1'b1; q_wr = 1'b1; q_addr = $urandom; q_wdata = $urandom;
        run_xfer(1'b0, a1, $urandom, 32'h600D_CAFE, 1'b0, 0, 10);
        q_en = 1'b0;
        n_vec++; if (o_stable_ok !== 1'b1)  begin n_bad++; $display("FAIL bp_stable: got %b want 1", o_stable_ok); end
        n_vec++; if (o_rdata !== 32'h600D_CAFE) begin n_bad++; $display("FAIL bp_rdata: got %h want 600dcafe", o_rdata); end
        n_vec++; if (o_release_ok !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", o_release_ok); end
        // The queued command is accepted the edge after the handshake.
        run_xfer(q_wr, q_addr, q_wdata, $urandom, 1'b0, 0, 0);
        n_vec++; if (o_setup_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_setup: got %b want 1", o_setup_ok); end
        n_vec++; if (o_lat != 3)          begin n_bad++; $display("FAIL b2b_latency: got %0d want 3", o_lat); end
        n_vec++; if (o_hold_ok !== 1'b1)  begin n_bad++; $display("FAIL b2b_apb_fields: got %b want 1", o_hold_ok); end
    endtask

    task automatic test_reset_mid_access();
        bit stale = 0;
        bus.PREADY = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.PENABLE !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_access: got penable=%b want 1", bus.PENABLE); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin n_bad++; $display("FAIL rstmid_apb_drop: got psel=%b penable=%b want 0 0", bus.PSEL, bus.PENABLE); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.PADDR !== 32'd0)    begin n_bad++; $display("FAIL rstmid_paddr: got %h want 0", bus.PADDR); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.PREADY = 1'b1; bus.PRDATA = $urandom; bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) stale = 1;
        end
        bus.PREADY = 1'b0; bus.rsp_ready = 1'b0;
        n_vec++; if (stale) begin n_bad++; $display("FAIL rstmid_stale: got stale activity=1 want 0"); end
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_cmd_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic        wr     = 1'($urandom);
            logic [31:0] addr   = $urandom;
            logic [31:0] wdata  = $urandom;
            logic [31:0] prdata = $urandom;
            logic        slverr = 1'($urandom);
            int          wcyc   = $urandom_range(0, 6);
            int          rdly   = $urandom_range(0, 3);
            int          e_acc;
            logic [31:0] e_rd;
            logic        e_err;
            ref_model(wr, prdata, slverr, wcyc, e_acc, e_rd, e_err);
            run_xfer(wr, addr, wdata, prdata, slverr, wcyc, rdly);
            n_vec++; if (o_acc != e_acc)      begin n_bad++; $display("FAIL rnd%0d_access_cycles: got %0d want %0d", i, o_acc, e_acc); end
            n_vec++; if (o_lat != e_acc + 2)  begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, o_lat, e_acc + 2); end
            n_vec++; if (o_rdata !== e_rd)    begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, o_rdata, e_rd); end
            n_vec++; if (o_err !== e_err)     begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", i, o_err, e_err); end
            n_vec++; if (o_setup_ok !== 1'b1 || o_hold_ok !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_apb: got setup=%b hold=%b want 1 1", i, o_setup_ok, o_hold_ok); end
            n_vec++; if (o_stable_ok !== 1'b1 || o_release_ok !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_rsp: got stable=%b release=%b want 1 1", i, o_stable_ok, o_release_ok); end
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_one_wait();
        test_slave_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion want summary before time limit");
        $fatal(1, "time limit reached");
    end

endmodule
